// File: rtl/axi_sram_pkg.sv
// Shared encodings for the AXI3 SRAM responder: FSM states, response/burst/size codes.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RD   = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  function automatic logic [31:0] beat_incr(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi_sram_slave_sram_2p.sv
// Two-port word RAM: one synchronous read port with registered output, one byte-enabled write port.
module sram_2p #(
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [MEM_AW-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [MEM_AW-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be
);

  logic [31:0] mem [2**MEM_AW];
  logic [31:0] rd_data_q, rd_data_d;

  // Output register only loads on a read so the data holds through R stalls.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a two-port word RAM; independent read and write FSMs, one transaction each.
// state  | meaning
// R_IDLE | waiting for AR, counting ready delay
// R_RD   | RAM read issued for current beat
// R_DATA | beat presented on R, held until rready
// W_IDLE | waiting for AW, counting ready delay
// W_DATA | accepting W beats until wlast
// W_RESP | B response presented until bready
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int MEM_AW      = 16,
  parameter int READY_DELAY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [15:0] CNT_RDY = 16'(READY_DELAY);

  r_state_e    r_state_q, r_state_d;
  logic [15:0] ar_cnt_q, ar_cnt_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [7:0]  rbeat_q, rbeat_d;

  w_state_e    w_state_q, w_state_d;
  logic [15:0] aw_cnt_q, aw_cnt_d;
  logic [3:0]  bid_q, bid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [2:0]  wsize_q, wsize_d;

  logic [31:0] ram_rdata;
  logic        ram_rd_en, ram_wr_en;

  // Burst type, awlen and wid do not affect behaviour: bursts are INCR, wlast ends writes.
  logic unused_ok;
  assign unused_ok = ^{arburst, awburst, awlen, wid};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      ar_cnt_q  <= '0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rbeat_q   <= '0;
      w_state_q <= W_IDLE;
      aw_cnt_q  <= '0;
      bid_q     <= '0;
      waddr_q   <= '0;
      wsize_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      ar_cnt_q  <= ar_cnt_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rbeat_q   <= rbeat_d;
      w_state_q <= w_state_d;
      aw_cnt_q  <= aw_cnt_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wsize_q   <= wsize_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_cnt_d  = ar_cnt_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rbeat_d   = rbeat_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready) begin
          r_state_d = R_RD;
          ar_cnt_d  = '0;
          rid_d     = arid;
          raddr_d   = araddr;
          rlen_d    = arlen;
          rsize_d   = arsize;
          rbeat_d   = '0;
        end else if (arvalid) begin
          ar_cnt_d = ar_cnt_q + 16'd1;
        end
      end
      R_RD: r_state_d = R_DATA;
      R_DATA: begin
        if (rready) begin
          if (rlast) begin
            r_state_d = R_IDLE;
          end else begin
            r_state_d = R_RD;
            raddr_d   = raddr_q + beat_incr(rsize_q);
            rbeat_d   = rbeat_q + 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_cnt_d  = aw_cnt_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wsize_d   = wsize_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready) begin
          w_state_d = W_DATA;
          aw_cnt_d  = '0;
          bid_d     = awid;
          waddr_d   = awaddr;
          wsize_d   = awsize;
        end else if (awvalid) begin
          aw_cnt_d = aw_cnt_q + 16'd1;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          waddr_d = waddr_q + beat_incr(wsize_q);
          if (wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    arready   = (r_state_q == R_IDLE) && (ar_cnt_q == CNT_RDY);
    rvalid    = (r_state_q == R_DATA);
    rlast     = rvalid && (rbeat_q == rlen_q);
    rid       = rid_q;
    rdata     = ram_rdata;
    rresp     = RESP_OKAY;
    ram_rd_en = (r_state_q == R_RD);
    awready   = (w_state_q == W_IDLE) && (aw_cnt_q == CNT_RDY);
    wready    = (w_state_q == W_DATA);
    bvalid    = (w_state_q == W_RESP);
    bid       = bid_q;
    bresp     = RESP_OKAY;
    ram_wr_en = wready && wvalid;
  end

  sram_2p #(.MEM_AW(MEM_AW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (ram_rd_en),
    .rd_addr (raddr_q[MEM_AW+1:2]),
    .rd_data (ram_rdata),
    .wr_en   (ram_wr_en),
    .wr_addr (waddr_q[MEM_AW+1:2]),
    .wr_data (wdata),
    .wr_be   (wstrb)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: drives and samples on the falling clock edge.
module tb_axi_sram_slave;
  import axi_sram_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic [3:0]  wstrb;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  logic        d3_arvalid, d3_awvalid, d3_wvalid;
  logic        d3_arready, d3_rlast, d3_rvalid, d3_awready, d3_wready, d3_bvalid;
  logic [3:0]  d3_rid, d3_bid;
  logic [31:0] d3_rdata;
  logic [1:0]  d3_rresp, d3_bresp;

  int          n_asserts = 0;
  int          n_fail = 0;
  logic [31:0] rd_buf [256];
  logic        rd_last [256];
  logic [3:0]  rd_rid;
  logic [1:0]  rd_resp;
  int          nbeats;
  int          first_lat;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_AW(16), .READY_DELAY(0)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_sram_slave #(.MEM_AW(4), .READY_DELAY(3)) dut3 (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(d3_arvalid), .arready(d3_arready),
    .rid(d3_rid), .rdata(d3_rdata), .rresp(d3_rresp), .rlast(d3_rlast), .rvalid(d3_rvalid),
    .rready(1'b1),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(d3_awvalid), .awready(d3_awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(1'b1), .wvalid(d3_wvalid),
    .wready(d3_wready),
    .bid(d3_bid), .bresp(d3_bresp), .bvalid(d3_bvalid), .bready(1'b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int nb,
                           input logic [31:0] d0, input logic [3:0] strb);
    int k;
    awid = id; awaddr = addr; awlen = 8'(nb - 1); awsize = SIZE_WORD; awburst = BURST_INCR;
    awvalid = 1'b1;
    k = 0;
    while (!awready && k < 50) begin @(negedge clk); k++; end
    chk("aw_handshake", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wdata = d0 + 32'(i); wstrb = strb; wlast = (i == nb - 1); wvalid = 1'b1;
      k = 0;
      while (!wready && k < 50) begin @(negedge clk); k++; end
      chk("w_ready", 32'(wready), 32'd1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("b_valid", 32'(bvalid), 32'd1);
    chk("b_id", 32'(bid), 32'(id));
    chk("b_resp", 32'(bresp), 32'(RESP_OKAY));
    @(negedge clk);
    chk("b_done", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input bit toggle);
    int k;
    bit hold;
    logic [31:0] held;
    nbeats = 0; first_lat = -1; hold = 1'b0; held = '0;
    arid = id; araddr = addr; arlen = len; arsize = SIZE_WORD; arburst = BURST_INCR;
    arvalid = 1'b1;
    k = 0;
    while (!arready && k < 50) begin @(negedge clk); k++; end
    chk("ar_handshake", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    k = 0;
    while (nbeats <= int'(len) && k < 200) begin
      rready = toggle ? (k % 2 == 0) : 1'b1;
      if (hold) begin
        chk("r_stall_valid", 32'(rvalid), 32'd1);
        chk("r_stall_data", rdata, held);
      end
      if (rvalid && first_lat < 0) first_lat = k + 1;
      if (rvalid && rready) begin
        rd_buf[nbeats] = rdata; rd_last[nbeats] = rlast; rd_rid = rid; rd_resp = rresp;
        nbeats++;
        hold = 1'b0;
      end else if (rvalid) begin
        hold = 1'b1; held = rdata;
      end
      @(negedge clk);
      k++;
    end
    rready = 1'b1;
    chk("r_beat_count", 32'(nbeats), 32'(int'(len) + 1));
  endtask

  initial begin
    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = SIZE_WORD; arburst = BURST_INCR; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = SIZE_WORD; awburst = BURST_INCR; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    d3_arvalid = 1'b0; d3_awvalid = 1'b0; d3_wvalid = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rid_bid", 32'({rid, bid}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", 32'({rresp, bresp}), 32'd0);
    chk("rst_d3_arready", 32'(d3_arready), 32'd0);

    // Ready-delay instance: valids raised in cycle 0, ready expected in cycle 3.
    reset = 1'b0;
    d3_arvalid = 1'b1; d3_awvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("d3_arready_c%0d", c), 32'(d3_arready), 32'(c == 3));
      chk($sformatf("d3_awready_c%0d", c), 32'(d3_awready), 32'(c == 3));
      if (c < 3) @(negedge clk);
    end
    @(negedge clk);
    d3_arvalid = 1'b0; d3_awvalid = 1'b0;
    chk("d3_arready_busy", 32'(d3_arready), 32'd0);
    chk("d3_wready_data", 32'(d3_wready), 32'd1);

    // Single read with latency check.
    axi_write(4'd0, 32'h10, 1, 32'h1234_5678, 4'hF);
    axi_read(4'd3, 32'h10, 8'd0, 1'b0);
    chk("t1_latency", 32'(first_lat), 32'd2);
    chk("t1_rdata", rd_buf[0], 32'h1234_5678);
    chk("t1_rid", 32'(rd_rid), 32'd3);
    chk("t1_rlast", 32'(rd_last[0]), 32'd1);
    chk("t1_rresp", 32'(rd_resp), 32'd0);

    // Byte-lane write over a zeroed word.
    axi_write(4'd1, 32'h20, 1, 32'h0, 4'hF);
    axi_write(4'd5, 32'h20, 1, 32'hAABB_CCDD, 4'b0010);
    axi_read(4'd0, 32'h20, 8'd0, 1'b0);
    chk("t2_rdata", rd_buf[0], 32'h0000_CC00);

    // Four-beat burst with rready toggling.
    axi_write(4'd2, 32'h100, 4, 32'd0, 4'hF);
    axi_read(4'd7, 32'h100, 8'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_rdata%0d", i), rd_buf[i], 32'(i));
      chk($sformatf("t3_rlast%0d", i), 32'(rd_last[i]), 32'(i == 3));
    end
    chk("t3_rid", 32'(rd_rid), 32'd7);

    // RAM index wraps: 0x40010 aliases word 0x10.
    axi_read(4'd1, 32'h0004_0010, 8'd0, 1'b0);
    chk("wrap_rdata", rd_buf[0], 32'h1234_5678);

    // Concurrent AR and AW to the same word: read sees pre-write data.
    axi_write(4'd0, 32'h40, 1, 32'h11, 4'hF);
    arid = 4'd9; araddr = 32'h40; arlen = 8'd0; arvalid = 1'b1;
    awid = 4'd6; awaddr = 32'h40; awlen = 8'd0; awvalid = 1'b1;
    chk("t5_both_ready", 32'({arready, awready}), 32'h3);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    wdata = 32'h22; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    chk("t5_rvalid", 32'(rvalid), 32'd1);
    chk("t5_rdata_old", rdata, 32'h11);
    chk("t5_rid", 32'(rid), 32'd9);
    chk("t5_bvalid", 32'(bvalid), 32'd1);
    chk("t5_bid", 32'(bid), 32'd6);
    @(negedge clk);
    chk("t5_idle", 32'({rvalid, bvalid}), 32'd0);
    axi_read(4'd0, 32'h40, 8'd0, 1'b0);
    chk("t5_rdata_new", rd_buf[0], 32'h22);

    // Reset while a beat is stalled on R.
    rready = 1'b0;
    arid = 4'd2; araddr = 32'h100; arlen = 8'd3; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    chk("t6_pre_rvalid", 32'(rvalid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rvalid", 32'(rvalid), 32'd0);
    chk("t6_arready", 32'(arready), 32'd1);
    chk("t6_rlast", 32'(rlast), 32'd0);
    reset = 1'b0; rready = 1'b1;
    axi_read(4'd0, 32'h10, 8'd0, 1'b0);
    chk("t6_ram_intact", rd_buf[0], 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
